// File: rtl/mem_burst_ctrl_if.sv
// Bundles the host command, write and read handshakes, and the external
// memory port of the PUF response memory burst controller.
//   slave  : the controller (mem_burst_ctrl) side
//   master : the host / memory side (testbench or enclosing block)
// Command : I_start, I_dir, I_base, I_len -> O_busy, O_done
// Write   : I_wvalid, I_wdata -> O_wready
// Read    : O_rvalid, O_rdata -> I_rready
// Memory  : O_ext_wen, O_ext_addr, O_ext_wdata, I_ext_data, I_core_wen
interface mem_burst_ctrl_if #(
    parameter int unsigned C_ADDRSIZE = 10,
    parameter int unsigned C_WORDSIZE = 8
);
    logic                  I_start;
    logic                  I_dir;
    logic [C_ADDRSIZE-1:0] I_base;
    logic [C_ADDRSIZE:0]   I_len;
    logic                  O_busy;
    logic                  O_done;
    logic                  I_wvalid;
    logic [C_WORDSIZE-1:0] I_wdata;
    logic                  O_wready;
    logic                  O_rvalid;
    logic [C_WORDSIZE-1:0] O_rdata;
    logic                  I_rready;
    logic                  I_core_wen;
    logic                  O_ext_wen;
    logic [C_ADDRSIZE-1:0] O_ext_addr;
    logic [C_WORDSIZE-1:0] O_ext_wdata;
    logic [C_WORDSIZE-1:0] I_ext_data;

    modport slave (
        input  I_start, I_dir, I_base, I_len, I_wvalid, I_wdata, I_rready,
               I_core_wen, I_ext_data,
        output O_busy, O_done, O_wready, O_rvalid, O_rdata, O_ext_wen,
               O_ext_addr, O_ext_wdata
    );

    modport master (
        output I_start, I_dir, I_base, I_len, I_wvalid, I_wdata, I_rready,
               I_core_wen, I_ext_data,
        input  O_busy, O_done, O_wready, O_rvalid, O_rdata, O_ext_wen,
               O_ext_addr, O_ext_wdata
    );
endinterface

// File: rtl/mem_burst_ctrl.sv
// Burst controller on the external port of the PUF response memory.
// A start command either streams host words into memory (write burst) or
// streams memory words out to the host through a registered output stage
// (read burst). Core-side writes have priority and stall write bursts.
// Ports:
//   I_clk  : clock, rising edge
//   I_rst  : synchronous active-high reset
//   bus    : mem_burst_ctrl_if.slave (command, write/read handshakes, memory port)
module mem_burst_ctrl #(
    parameter int unsigned C_ADDRSIZE = 10,
    parameter int unsigned C_WORDSIZE = 8
) (
    input logic            I_clk,
    input logic            I_rst,
    mem_burst_ctrl_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StWrite, StRead, StDone} state_e;

    state_e                state_q, state_d;
    logic [C_ADDRSIZE-1:0] addr_q, addr_d;
    // Words still to be transferred (write) or accepted by the host (read).
    logic [C_ADDRSIZE:0]   remain_q, remain_d;
    // Read only: words still to be loaded into the output register.
    logic [C_ADDRSIZE:0]   pend_q, pend_d;
    logic                  rvalid_q, rvalid_d;
    logic [C_WORDSIZE-1:0] rdata_q, rdata_d;

    logic wready;
    logic ext_wen;
    logic load;
    logic accept;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        pend_d   = pend_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        wready   = 1'b0;
        ext_wen  = 1'b0;
        load     = 1'b0;
        accept   = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.I_start) begin
                    addr_d   = bus.I_base;
                    remain_d = bus.I_len;
                    pend_d   = bus.I_len;
                    if (bus.I_len == '0) begin
                        state_d = StDone;
                    end else if (bus.I_dir) begin
                        state_d = StRead;
                    end else begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                // Core writes own the memory this cycle; host must hold its word.
                wready = ~bus.I_core_wen;
                if (bus.I_wvalid && wready) begin
                    ext_wen  = 1'b1;
                    addr_d   = addr_q + 1'b1;
                    remain_d = remain_q - 1'b1;
                    if (remain_q == 1) begin
                        state_d = StDone;
                    end
                end
            end
            StRead: begin
                accept = rvalid_q & bus.I_rready;
                load   = (~rvalid_q | bus.I_rready) & (pend_q != '0);
                if (load) begin
                    rdata_d  = bus.I_ext_data;
                    rvalid_d = 1'b1;
                    addr_d   = addr_q + 1'b1;
                    pend_d   = pend_q - 1'b1;
                end else if (accept) begin
                    rvalid_d = 1'b0;
                end
                if (accept) begin
                    remain_d = remain_q - 1'b1;
                    // Last accept implies nothing left to load, so rvalid drops too.
                    if (remain_q == 1) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // No memory write may escape in a reset cycle.
        if (I_rst) begin
            wready  = 1'b0;
            ext_wen = 1'b0;
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            remain_q <= '0;
            pend_q   <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            pend_q   <= pend_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign bus.O_busy      = (state_q != StIdle);
    assign bus.O_done      = (state_q == StDone);
    assign bus.O_wready    = wready;
    assign bus.O_ext_wen   = ext_wen;
    assign bus.O_ext_addr  = addr_q;
    assign bus.O_ext_wdata = bus.I_wdata;
    assign bus.O_rvalid    = rvalid_q;
    assign bus.O_rdata     = rdata_q;

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Self-checking bench for mem_burst_ctrl: models the response memory with a
// prioritised core port, scoreboards external writes and read words, and
// checks burst timing, stalls, wrap-around, reset abort and ignored starts.
module tb_mem_burst_ctrl;

    localparam int unsigned A = 10;
    localparam int unsigned W = 8;
    localparam int unsigned DEPTH = 1 << A;

    typedef struct packed {
        logic [A-1:0] addr;
        logic [W-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    logic mem_clr;
    logic [A-1:0] core_addr;
    logic [W-1:0] core_wdata;

    mem_burst_ctrl_if #(.C_ADDRSIZE(A), .C_WORDSIZE(W)) bus ();

    mem_burst_ctrl #(.C_ADDRSIZE(A), .C_WORDSIZE(W)) dut (
        .I_clk (clk),
        .I_rst (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Response memory: core port has priority, reads combinational.
    logic [W-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else if (bus.I_core_wen) begin
            mem[core_addr] <= core_wdata;
        end else if (bus.O_ext_wen) begin
            mem[bus.O_ext_addr] <= bus.O_ext_wdata;
        end
    end
    assign bus.I_ext_data = mem[bus.O_ext_addr];

    logic [W-1:0] ref_mem [DEPTH];
    wr_t          wq[$];
    logic [W-1:0] rq[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int wen_cnt = 0;
    int rvalid_cnt = 0;
    int rd_hs_cnt = 0;
    logic         hold_pend = 1'b0;
    logic [W-1:0] hold_data = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor / scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.O_ext_wen) begin
                wen_cnt++;
                if (wq.size() == 0) begin
                    check_eq("wr_unexpected", 1, 0);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    check_eq("wr_addr", 32'(bus.O_ext_addr), 32'(e.addr));
                    check_eq("wr_data", 32'(bus.O_ext_wdata), 32'(e.data));
                end
            end
            if (bus.I_core_wen) check_eq("core_block_wen", 32'(bus.O_ext_wen), 0);
            if (bus.O_rvalid) rvalid_cnt++;
            if (hold_pend && bus.O_rvalid) check_eq("rd_hold", 32'(bus.O_rdata), 32'(hold_data));
            hold_pend = bus.O_rvalid & ~bus.I_rready;
            hold_data = bus.O_rdata;
            if (bus.O_rvalid && bus.I_rready) begin
                rd_hs_cnt++;
                if (rq.size() == 0) begin
                    check_eq("rd_unexpected", 1, 0);
                end else begin
                    check_eq("rd_data", 32'(bus.O_rdata), 32'(rq.pop_front()));
                end
            end
            if (bus.O_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end else begin
            hold_pend = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int g = 0;
        while (bus.O_busy && g < 60) begin
            tick();
            g++;
        end
        if (bus.O_busy) check_eq("idle_timeout", 1, 0);
    endtask

    task automatic start_burst(input logic dir, input logic [A-1:0] base, input int len,
                               output int k);
        bus.I_start = 1'b1;
        bus.I_dir   = dir;
        bus.I_base  = base;
        bus.I_len   = (A+1)'(len);
        tick();
        bus.I_start = 1'b0;
        k = cyc;
        check_eq("start_busy", 32'(bus.O_busy), 1);
    endtask

    task automatic core_write(input logic [A-1:0] a, input logic [W-1:0] d);
        core_addr      = a;
        core_wdata     = d;
        bus.I_core_wen = 1'b1;
        ref_mem[a]     = d;
        tick();
        bus.I_core_wen = 1'b0;
    endtask

    task automatic write_burst(input logic [A-1:0] base, input int n, input logic [W-1:0] d0,
                               input int stall_idx);
        int k;
        int d_before;
        int stalls = 0;
        logic hs;
        d_before = done_cnt;
        start_burst(1'b0, base, n, k);
        for (int i = 0; i < n; i++) begin
            int g = 0;
            wr_t e;
            e.addr = base + A'(i);
            e.data = d0 + W'(i);
            wq.push_back(e);
            ref_mem[e.addr] = e.data;
            bus.I_wvalid = 1'b1;
            bus.I_wdata  = e.data;
            if (i == stall_idx) begin
                core_addr      = 10'h200;
                core_wdata     = 8'h5A;
                bus.I_core_wen = 1'b1;
                ref_mem[10'h200] = 8'h5A;
                #1;
                check_eq("stall_wready", 32'(bus.O_wready), 0);
                tick();
                bus.I_core_wen = 1'b0;
                stalls++;
            end
            do begin
                #1;
                hs = bus.O_wready & bus.I_wvalid;
                tick();
                g++;
            end while (!hs && g < 20);
            if (!hs) check_eq("wr_timeout", 1, 0);
        end
        bus.I_wvalid = 1'b0;
        wait_idle();
        check_eq("wr_done_cnt", 32'(done_cnt - d_before), 1);
        check_eq("wr_done_cyc", 32'(done_cyc), 32'(k + n + stalls));
        check_eq("wr_queue_empty", 32'(wq.size()), 0);
    endtask

    // pat bit c gives I_rready in the c-th cycle after the first rvalid cycle.
    task automatic read_burst(input logic [A-1:0] base, input int n, input logic [31:0] pat);
        int k;
        int c = 0;
        int g = 0;
        int d_before;
        d_before = done_cnt;
        for (int i = 0; i < n; i++) rq.push_back(ref_mem[base + A'(i)]);
        bus.I_rready = 1'b1;
        start_burst(1'b1, base, n, k);
        check_eq("rd_lat_load", 32'(bus.O_rvalid), 0);
        bus.I_rready = pat[0];
        tick();
        check_eq("rd_lat_valid", 32'(bus.O_rvalid), 1);
        while (bus.O_busy && g < n * 3 + 40) begin
            bus.I_rready = (c < 32) ? pat[c] : 1'b1;
            tick();
            c++;
            g++;
        end
        if (bus.O_busy) check_eq("rd_timeout", 1, 0);
        bus.I_rready = 1'b0;
        check_eq("rd_queue_empty", 32'(rq.size()), 0);
        check_eq("rd_done_cnt", 32'(done_cnt - d_before), 1);
        if (pat == 32'hFFFF_FFFF) check_eq("rd_done_cyc", 32'(done_cyc), 32'(k + n + 1));
    endtask

    initial begin
        int k;
        int w0;
        int v0;
        int d0;
        int g;
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
        rst            = 1'b1;
        mem_clr        = 1'b1;
        core_addr      = '0;
        core_wdata     = '0;
        bus.I_start    = 1'b0;
        bus.I_dir      = 1'b0;
        bus.I_base     = '0;
        bus.I_len      = '0;
        bus.I_wvalid   = 1'b1;
        bus.I_wdata    = 8'h33;
        bus.I_rready   = 1'b0;
        bus.I_core_wen = 1'b0;
        tick();
        tick();
        check_eq("rst_busy", 32'(bus.O_busy), 0);
        check_eq("rst_done", 32'(bus.O_done), 0);
        check_eq("rst_wready", 32'(bus.O_wready), 0);
        check_eq("rst_rvalid", 32'(bus.O_rvalid), 0);
        check_eq("rst_rdata", 32'(bus.O_rdata), 0);
        check_eq("rst_ext_wen", 32'(bus.O_ext_wen), 0);
        check_eq("rst_ext_addr", 32'(bus.O_ext_addr), 0);
        bus.I_wvalid = 1'b0;
        rst     = 1'b0;
        mem_clr = 1'b0;
        tick();

        // Write burst across the top-of-memory wrap.
        write_burst(10'h3FE, 4, 8'hA1, -1);
        // Write burst with a core write stalling the second word.
        write_burst(10'h100, 3, 8'hB1, 1);

        // Read back everything written so far.
        read_burst(10'h3FE, 4, 32'hFFFF_FFFF);
        read_burst(10'h100, 3, 32'hFFFF_FFFF);
        read_burst(10'h200, 1, 32'hFFFF_FFFF);

        // Read with host back-pressure 1,0,1,1,0,1.
        for (int i = 0; i < 4; i++) core_write(10'h010 + A'(i), 8'h11 + W'(i));
        read_burst(10'h010, 4, 32'hFFFF_FFED);

        // Zero-length bursts in both directions.
        for (int dir = 0; dir < 2; dir++) begin
            w0 = wen_cnt;
            v0 = rvalid_cnt;
            d0 = done_cnt;
            bus.I_wvalid = 1'b1;
            bus.I_rready = 1'b1;
            start_burst(dir[0], 10'h055, 0, k);
            check_eq("len0_done", 32'(bus.O_done), 1);
            tick();
            check_eq("len0_idle", 32'(bus.O_busy), 0);
            tick();
            bus.I_wvalid = 1'b0;
            bus.I_rready = 1'b0;
            check_eq("len0_done_cyc", 32'(done_cyc), 32'(k));
            check_eq("len0_done_cnt", 32'(done_cnt - d0), 1);
            check_eq("len0_no_wen", 32'(wen_cnt - w0), 0);
            check_eq("len0_no_rvalid", 32'(rvalid_cnt - v0), 0);
        end

        // Reset in the middle of a read burst.
        d0 = rd_hs_cnt;
        for (int i = 0; i < 8; i++) rq.push_back(ref_mem[10'h3FE + A'(i)]);
        bus.I_rready = 1'b1;
        start_burst(1'b1, 10'h3FE, 8, k);
        g = 0;
        while (!(bus.O_rvalid && (rd_hs_cnt - d0) == 2) && g < 20) begin
            tick();
            g++;
        end
        if (g >= 20) check_eq("abort_timeout", 1, 0);
        d0  = done_cnt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("abort_busy", 32'(bus.O_busy), 0);
        check_eq("abort_rvalid", 32'(bus.O_rvalid), 0);
        check_eq("abort_addr", 32'(bus.O_ext_addr), 0);
        check_eq("abort_rdata", 32'(bus.O_rdata), 0);
        rq.delete();
        bus.I_rready = 1'b0;
        tick();
        tick();
        check_eq("abort_no_done", 32'(done_cnt - d0), 0);
        read_burst(10'h010, 4, 32'hFFFF_FFFF);

        // Start pulses during READ and DONE are ignored.
        d0 = done_cnt;
        for (int i = 0; i < 3; i++) rq.push_back(ref_mem[10'h100 + A'(i)]);
        bus.I_rready = 1'b1;
        start_burst(1'b1, 10'h100, 3, k);
        bus.I_start = 1'b1;
        bus.I_dir   = 1'b0;
        bus.I_base  = 10'h000;
        bus.I_len   = 11'd5;
        tick();
        bus.I_start = 1'b0;
        tick();
        tick();
        tick();
        check_eq("ign_done", 32'(bus.O_done), 1);
        bus.I_start = 1'b1;
        tick();
        bus.I_start = 1'b0;
        check_eq("ign_busy", 32'(bus.O_busy), 0);
        tick();
        check_eq("ign_busy_hold", 32'(bus.O_busy), 0);
        check_eq("ign_addr", 32'(bus.O_ext_addr), 32'h103);
        check_eq("ign_done_cnt", 32'(done_cnt - d0), 1);
        check_eq("ign_queue_empty", 32'(rq.size()), 0);
        bus.I_rready = 1'b0;

        // Full-memory sweep returns the address to its base.
        read_burst(10'h3FE, int'(DEPTH), 32'hFFFF_FFFF);
        check_eq("sweep_addr", 32'(bus.O_ext_addr), 32'h3FE);

        check_eq("wq_final_empty", 32'(wq.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
